// File: rtl/demux32_pkg.sv
// Shared types and defaults for the buffered 1-to-2 word demultiplexer.
package demux32_pkg;

  localparam int unsigned DefWidth = 32;
  localparam int unsigned DefDepth = 2;
  localparam int unsigned CntWidth = 16;

  // Destination index: 0 routes to out0, 1 routes to out1.
  typedef logic sel_t;

endpackage

// File: rtl/fifo32_sync.sv
// Single-clock FIFO with registered pointers/count, head-of-queue output and sync active-low reset.
module fifo32_sync
  import demux32_pkg::*;
#(
  parameter int unsigned WIDTH = DefWidth,
  parameter int unsigned DEPTH = DefDepth
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_valid,
  output logic             o_full
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] FullCount = CW'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [CW-1:0]    r_count;

  logic w_empty;
  logic w_push;
  logic w_pop;

  assign o_full  = (r_count == FullCount);
  assign w_empty = (r_count == '0);
  // No bypass: a full FIFO refuses a push even if it is popped in the same cycle.
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !w_empty;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wptr] <= i_data;
        r_wptr        <= r_wptr + AW'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + AW'(1);
      end
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_valid = !w_empty;
  assign o_data  = w_empty ? '0 : r_mem[r_rptr];

endmodule

// File: rtl/demux32_buf.sv
// Buffered 1-to-2 word demultiplexer: one FIFO per destination, independent valid/ready outputs.
// Optional per-destination accept counters are built when DEMUX32_STATS_EN is defined.
module demux32_buf
  import demux32_pkg::*;
#(
  parameter int unsigned WIDTH = DefWidth,
  parameter int unsigned DEPTH = DefDepth
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  sel_t             in_sel,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out0_data,
  output logic             out0_valid,
  input  logic             out0_ready,
  output logic [WIDTH-1:0] out1_data,
  output logic             out1_valid,
  input  logic             out1_ready
`ifdef DEMUX32_STATS_EN
  ,
  output logic [CntWidth-1:0] cnt0,
  output logic [CntWidth-1:0] cnt1
`endif
);

  logic w_full0;
  logic w_full1;
  logic w_accept;
  logic w_push0;
  logic w_push1;

  // Readiness depends only on the selected FIFO's registered state, never on outN_ready.
  assign in_ready = in_sel ? !w_full1 : !w_full0;
  assign w_accept = in_valid && in_ready;
  assign w_push0  = w_accept && !in_sel;
  assign w_push1  = w_accept && in_sel;

  fifo32_sync #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo0 (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push0),
    .i_data  (in_data),
    .i_pop   (out0_ready),
    .o_data  (out0_data),
    .o_valid (out0_valid),
    .o_full  (w_full0)
  );

  fifo32_sync #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo1 (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push1),
    .i_data  (in_data),
    .i_pop   (out1_ready),
    .o_data  (out1_data),
    .o_valid (out1_valid),
    .o_full  (w_full1)
  );

`ifdef DEMUX32_STATS_EN
  logic [CntWidth-1:0] r_cnt0;
  logic [CntWidth-1:0] r_cnt1;

  // Counters wrap naturally at 2^CntWidth.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt0 <= '0;
      r_cnt1 <= '0;
    end else begin
      if (w_push0) r_cnt0 <= r_cnt0 + CntWidth'(1);
      if (w_push1) r_cnt1 <= r_cnt1 + CntWidth'(1);
    end
  end

  assign cnt0 = r_cnt0;
  assign cnt1 = r_cnt1;
`endif

endmodule

// File: tb/tb_demux32_buf.sv
// Scoreboard bench for demux32_buf: a negedge monitor keeps per-FIFO expected queues,
// and the stimulus process adds hand-computed directed checks at key points.
module tb_demux32_buf;

  localparam int unsigned W = 32;
  localparam int unsigned D = 2;

  logic          clk;
  logic          rst_n;
  logic [W-1:0]  in_data;
  logic          in_sel;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  out0_data;
  logic          out0_valid;
  logic          out0_ready;
  logic [W-1:0]  out1_data;
  logic          out1_valid;
  logic          out1_ready;
`ifdef DEMUX32_STATS_EN
  logic [15:0]   cnt0;
  logic [15:0]   cnt1;
  logic [15:0]   m_cnt0;
  logic [15:0]   m_cnt1;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  logic [W-1:0] q0[$];
  logic [W-1:0] q1[$];
  bit           armed = 0;

  demux32_buf #(
    .WIDTH (W),
    .DEPTH (D)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_data    (in_data),
    .in_sel     (in_sel),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out0_data  (out0_data),
    .out0_valid (out0_valid),
    .out0_ready (out0_ready),
    .out1_data  (out1_data),
    .out1_valid (out1_valid),
    .out1_ready (out1_ready)
`ifdef DEMUX32_STATS_EN
    ,
    .cnt0       (cnt0),
    .cnt1       (cnt1)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: compare outputs with the model, then apply what the coming edge will do.
  always @(negedge clk) begin
    bit acc;
    if (armed) begin
      chk("out0_valid", {31'd0, out0_valid}, {31'd0, q0.size() != 0});
      chk("out0_data", out0_data, (q0.size() != 0) ? q0[0] : '0);
      chk("out1_valid", {31'd0, out1_valid}, {31'd0, q1.size() != 0});
      chk("out1_data", out1_data, (q1.size() != 0) ? q1[0] : '0);
      chk("in_ready", {31'd0, in_ready},
          {31'd0, in_sel ? (q1.size() < D) : (q0.size() < D)});
`ifdef DEMUX32_STATS_EN
      chk("cnt0", {16'd0, cnt0}, {16'd0, m_cnt0});
      chk("cnt1", {16'd0, cnt1}, {16'd0, m_cnt1});
`endif
    end
    if (!rst_n) begin
      q0.delete();
      q1.delete();
`ifdef DEMUX32_STATS_EN
      m_cnt0 = '0;
      m_cnt1 = '0;
`endif
      armed = 1;
    end else if (armed) begin
      acc = in_valid && (in_sel ? (q1.size() < D) : (q0.size() < D));
      if (out0_ready && q0.size() != 0) void'(q0.pop_front());
      if (out1_ready && q1.size() != 0) void'(q1.pop_front());
      if (acc) begin
        if (in_sel) q1.push_back(in_data);
        else        q0.push_back(in_data);
`ifdef DEMUX32_STATS_EN
        if (in_sel) m_cnt1 = m_cnt1 + 16'd1;
        else        m_cnt0 = m_cnt0 + 16'd1;
`endif
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic s, input logic [W-1:0] d);
    in_valid = 1'b1;
    in_sel   = s;
    in_data  = d;
  endtask

  initial begin
    rst_n      = 1'b0;
    in_valid   = 1'b1;
    in_sel     = 1'b0;
    in_data    = 32'hDEAD_BEEF;
    out0_ready = 1'b1;
    out1_ready = 1'b1;

    // Reset held for two edges with a word offered.
    step(2);
    chk("rst in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst out0_valid", {31'd0, out0_valid}, 32'd0);
    chk("rst out1_valid", {31'd0, out1_valid}, 32'd0);
    chk("rst out0_data", out0_data, 32'd0);
    chk("rst out1_data", out1_data, 32'd0);
    rst_n    = 1'b1;
    in_valid = 1'b0;
    step(1);

    // Routing.
    offer(1'b0, 32'd11);
    step(1);
    chk("route out0_data", out0_data, 32'd11);
    chk("route out1_valid", {31'd0, out1_valid}, 32'd0);
    offer(1'b1, 32'd110);
    step(1);
    chk("route out1_data", out1_data, 32'd110);
    chk("route out0 drained", {31'd0, out0_valid}, 32'd0);
    in_valid = 1'b0;
    step(1);

    // Full FIFO0 with backpressure; FIFO1 still accepts.
    out0_ready = 1'b0;
    offer(1'b0, 32'd1);
    step(1);
    offer(1'b0, 32'd2);
    step(1);
    offer(1'b0, 32'd3);
    #1;
    chk("full in_ready", {31'd0, in_ready}, 32'd0);
    offer(1'b1, 32'd77);
    #1;
    chk("other side ready", {31'd0, in_ready}, 32'd1);
    step(1);
    chk("other side data", out1_data, 32'd77);
    offer(1'b0, 32'd3);
    out0_ready = 1'b1;
    step(1);
    chk("pop order 2", out0_data, 32'd2);
    step(1);
    chk("pop order 3", out0_data, 32'd3);
    in_valid = 1'b0;
    step(1);
    chk("drained", {31'd0, out0_valid}, 32'd0);

    // Simultaneous push and pop keep the count at one.
    out0_ready = 1'b0;
    offer(1'b0, 32'd12);
    step(1);
    out0_ready = 1'b1;
    offer(1'b0, 32'd40);
    step(1);
    chk("pushpop data", out0_data, 32'd40);
    in_valid = 1'b0;
    step(1);
    chk("pushpop count 1", {31'd0, out0_valid}, 32'd0);

    // Mid-stream reset discards buffered words.
    out0_ready = 1'b0;
    out1_ready = 1'b0;
    offer(1'b0, 32'd5); step(1);
    offer(1'b0, 32'd6); step(1);
    offer(1'b1, 32'd7); step(1);
    offer(1'b1, 32'd8); step(1);
    chk("pre-rst out1_data", out1_data, 32'd7);
    rst_n = 1'b0;
    step(1);
    rst_n = 1'b1;
    chk("mid rst out0_valid", {31'd0, out0_valid}, 32'd0);
    chk("mid rst out1_data", out1_data, 32'd0);
    chk("mid rst in_ready", {31'd0, in_ready}, 32'd1);
    out0_ready = 1'b1;
    out1_ready = 1'b1;
    offer(1'b1, 32'd9);
    step(1);
    chk("post rst data", out1_data, 32'd9);
    in_valid = 1'b0;
    step(1);

`ifdef DEMUX32_STATS_EN
    rst_n = 1'b0;
    step(1);
    rst_n = 1'b1;
    offer(1'b1, 32'd1);
    for (int i = 0; i < 65537; i++) begin
      in_data = i;
      step(1);
    end
    in_valid = 1'b0;
    chk("wrap cnt1", {16'd0, cnt1}, 32'd1);
    chk("wrap cnt0", {16'd0, cnt0}, 32'd0);
`endif

    step(2);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
